// File: rtl/password_check.sv
// Password comparator with timed unlock window and lockout alarm.
// One evaluation per confirm press; outputs are all registered.
module password_check #(
  parameter int MAX_ERR       = 3,
  parameter int UNLOCK_CYCLES = 8,
  parameter int LOCK_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] ipw_6,
  input  logic [5:0] npw_6,
  input  logic       set_status,
  input  logic       confirm,
  output logic       unlock,
  output logic       alarm,
  output logic [1:0] err_cnt,
  output logic [1:0] chk_state
);

  localparam int TMAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OPEN  = 2'b01,
    ALARM = 2'b10,
    BAD   = 2'b11
  } state_t;

  state_t        state, state_d;
  logic [1:0]    err_d;
  logic [TW-1:0] tmr, tmr_d;
  logic          confirm_q;
  logic          press;
  logic [2:0]    err_inc;

  assign press   = confirm & ~confirm_q;
  assign err_inc = {1'b0, err_cnt} + 3'd1;

  // Timers load N-1 and leave on the edge that sees zero, giving exactly N cycles.
  always_comb begin
    state_d = state;
    err_d   = err_cnt;
    tmr_d   = tmr;
    case (state)
      IDLE: begin
        if (press && !set_status) begin
          if (ipw_6 == npw_6) begin
            state_d = OPEN;
            err_d   = 2'd0;
            tmr_d   = TW'(UNLOCK_CYCLES - 1);
          end else if (err_inc >= 3'(MAX_ERR)) begin
            state_d = ALARM;
            err_d   = 2'(MAX_ERR);
            tmr_d   = TW'(LOCK_CYCLES - 1);
          end else begin
            err_d = err_inc[1:0];
          end
        end
      end
      OPEN: begin
        // Frozen while the password is being changed.
        if (!set_status) begin
          if (tmr == '0) state_d = IDLE;
          else           tmr_d   = tmr - TW'(1);
        end
      end
      ALARM: begin
        if (tmr == '0) begin
          state_d = IDLE;
          err_d   = 2'd0;
        end else begin
          tmr_d = tmr - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        err_d   = 2'd0;
        tmr_d   = '0;
      end
    endcase
  end

  // confirm_q resets high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      err_cnt   <= 2'd0;
      tmr       <= '0;
      confirm_q <= 1'b1;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
      chk_state <= 2'b00;
    end else begin
      state     <= state_d;
      err_cnt   <= err_d;
      tmr       <= tmr_d;
      confirm_q <= confirm;
      unlock    <= (state_d == OPEN);
      alarm     <= (state_d == ALARM);
      chk_state <= state_d;
    end
  end

endmodule

// File: tb/tb_password_check.sv
// Directed bench for password_check: open window, lockout, hold, freeze, reset.
module tb_password_check;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] ipw_6, npw_6;
  logic       set_status, confirm;
  logic       unlock, alarm;
  logic [1:0] err_cnt, chk_state;
  int         n_chk = 0;
  int         n_err = 0;
  int         n;

  localparam logic [5:0] PW  = 6'b101010;
  localparam logic [5:0] BAD = 6'b000001;

  password_check #(.MAX_ERR(3), .UNLOCK_CYCLES(8), .LOCK_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .ipw_6(ipw_6), .npw_6(npw_6),
    .set_status(set_status), .confirm(confirm),
    .unlock(unlock), .alarm(alarm), .err_cnt(err_cnt), .chk_state(chk_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on negedge; outputs observed on negedge reflect the prior posedge.
  task automatic press();
    @(negedge clk) confirm = 1'b1;
    @(negedge clk) confirm = 1'b0;
  endtask

  // mode 0: plain, 1: toggle confirm each cycle, 2: set_status high for n in [2,12)
  task automatic count_unlock(input int mode, output int cnt);
    cnt = 0;
    while (unlock && cnt < 100) begin
      if (mode == 2) set_status = (cnt >= 2 && cnt < 12);
      cnt++;
      @(negedge clk);
    end
    set_status = 1'b0;
  endtask

  task automatic count_alarm(input int mode, output int cnt);
    cnt = 0;
    while (alarm && cnt < 100) begin
      if (mode == 1) confirm = cnt[0];
      cnt++;
      @(negedge clk);
    end
    confirm = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ipw_6 = PW; npw_6 = PW; set_status = 1'b0; confirm = 1'b0;
    #12;
    chk("rst_unlock", unlock, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_state", chk_state, 0);
    @(negedge clk) rst = 1'b0;

    // correct entry opens for exactly 8 cycles
    press();
    chk("ok_state", chk_state, 1);
    chk("ok_unlock", unlock, 1);
    chk("ok_err", err_cnt, 0);
    count_unlock(0, n);
    chk("ok_len", n, 8);
    chk("ok_idle", chk_state, 0);

    // three wrong entries -> 16-cycle alarm, presses ignored meanwhile
    ipw_6 = BAD;
    press(); chk("w1_err", err_cnt, 1);
    press(); chk("w2_err", err_cnt, 2);
    press();
    chk("w3_alarm", alarm, 1);
    chk("w3_err", err_cnt, 3);
    chk("w3_state", chk_state, 2);
    count_alarm(1, n);
    chk("alarm_len", n, 16);
    chk("alarm_end_err", err_cnt, 0);
    chk("alarm_end_state", chk_state, 0);
    @(negedge clk);
    chk("alarm_after_err", err_cnt, 0);

    // two wrong, then correct clears the count
    press(); chk("ww_err1", err_cnt, 1);
    press(); chk("ww_err2", err_cnt, 2);
    ipw_6 = PW;
    press();
    chk("wwc_err", err_cnt, 0);
    chk("wwc_unlock", unlock, 1);
    count_unlock(0, n);
    chk("wwc_len", n, 8);

    // held confirm counts once; press while setting is discarded
    ipw_6 = BAD;
    @(negedge clk) confirm = 1'b1;
    repeat (20) @(negedge clk);
    confirm = 1'b0;
    chk("hold_err", err_cnt, 1);
    set_status = 1'b1;
    press();
    chk("set_err", err_cnt, 1);
    chk("set_state", chk_state, 0);
    set_status = 1'b0;

    // password change while open: stored value sampled only on press
    ipw_6 = PW;
    press();
    chk("frz_unlock", unlock, 1);
    chk("frz_err", err_cnt, 0);
    npw_6 = 6'b111111;
    count_unlock(2, n);
    chk("frz_len", n, 18);
    press();
    chk("newpw_err", err_cnt, 1);
    ipw_6 = 6'b111111;
    press();
    chk("newpw_unlock", unlock, 1);
    count_unlock(0, n);

    // reset mid-alarm clears immediately; held confirm through release is no press
    ipw_6 = BAD;
    press(); press(); press();
    chk("pre_rst_alarm", alarm, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_alarm", alarm, 0);
    chk("arst_unlock", unlock, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_state", chk_state, 0);
    confirm = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_rel_err", err_cnt, 0);
    confirm = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
